// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue arbiter.
// Holds the ALU opcode width and fixed opcodes, the arbiter FSM state
// encoding, and a saturating counter helper.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 5'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc32 = v;
    end else begin
      sat_inc32 = v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_rr.sv
// Combinational round-robin picker.
// Returns the first asserted request at or after the pointer, wrapping
// around, as a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_o
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [ID_W-1:0] cand_idx;
      cand_idx = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters.
// One operation at a time walks IDLE -> ISSUE -> CAPTURE -> RESP: the
// winning request is latched, driven to the ALU for one cycle, its result
// captured the following cycle and returned with the requester ID over a
// valid/ready response channel.
// Optional feature macro: ALU_ARB_PERF_EN adds saturating issue and stall
// counters on perf_issue_cnt_o / perf_stall_cnt_o.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = ALU_OP_W,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_rs1_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_rs2_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  output logic [DATA_W-1:0]         alu_rs1_o,
  output logic [DATA_W-1:0]         alu_rs2_o,
  output logic [OP_W-1:0]           alu_op_o,
  input  logic [DATA_W-1:0]         alu_rd_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_data_o
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]               perf_issue_cnt_o,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DATA_W-1:0]  alu_rs1_q, alu_rs1_d;
  logic [DATA_W-1:0]  alu_rs2_q, alu_rs2_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               any_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               hs_s;
  logic [DATA_W-1:0]  sel_rs1_s;
  logic [DATA_W-1:0]  sel_rs2_s;
  logic [OP_W-1:0]    sel_op_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .any_o     (any_s)
  );

  // One-hot operand mux: pick the granted requester's rs1/rs2/op.
  always_comb begin
    sel_rs1_s = '0;
    sel_rs2_s = '0;
    sel_op_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_s[k]) begin
        sel_rs1_s = sel_rs1_s | req_rs1_i[k*DATA_W +: DATA_W];
        sel_rs2_s = sel_rs2_s | req_rs2_i[k*DATA_W +: DATA_W];
        sel_op_s  = sel_op_s  | req_op_i[k*OP_W +: OP_W];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // FSM next state, issue/response register updates and request accept.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    alu_rs1_d   = '0;
    alu_rs2_d   = '0;
    alu_op_d    = OP_W'(ALU_OP_NOP);
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    req_ready_s = '0;
    hs_s        = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is masked during reset so nothing appears accepted.
        if (any_s && rst_n_i) begin
          req_ready_s = gnt_s;
          hs_s        = 1'b1;
          id_d        = gnt_idx_s;
          alu_rs1_d   = sel_rs1_s;
          alu_rs2_d   = sel_rs2_s;
          alu_op_d    = sel_op_s;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // ALU inputs were presented this cycle; they return to zero next.
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d  = alu_rd_i;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (id_q == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = id_q + ID_W'(1);
          end
          state_d = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      alu_rs1_q   <= '0;
      alu_rs2_q   <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      alu_rs1_q   <= alu_rs1_d;
      alu_rs2_q   <= alu_rs2_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o = req_ready_s;
  assign alu_rs1_o   = alu_rs1_q;
  assign alu_rs2_o   = alu_rs2_q;
  assign alu_op_o    = alu_op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // Count accepted requests and cycles where someone waits without a handshake.
  always_comb begin
    perf_issue_cnt_d = perf_issue_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (hs_s) begin
      perf_issue_cnt_d = sat_inc32(perf_issue_cnt_q);
    end else if (|req_valid_i) begin
      perf_stall_cnt_d = sat_inc32(perf_stall_cnt_q);
    end else begin
      perf_stall_cnt_d = perf_stall_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      perf_issue_cnt_q <= 32'd0;
      perf_stall_cnt_q <= 32'd0;
    end else begin
      perf_issue_cnt_q <= perf_issue_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_issue_cnt_o = perf_issue_cnt_q;
  assign perf_stall_cnt_o = perf_stall_cnt_q;
`endif

endmodule
